// File: rtl/instr_dec_pkg.sv
// Shared definitions for the instruction decode stage: field geometry helpers,
// the default-configuration payload layout, opcode names and default class masks.
package instr_dec_pkg;

  localparam int DEF_COND_W = 2;
  localparam int DEF_OP_W   = 4;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_TAG_W  = 4;

  localparam logic [15:0] DEF_SHIFT_OP_MASK   = 16'h0000;
  localparam logic [15:0] DEF_ILLEGAL_OP_MASK = 16'h0000;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_TRAP = 4'd15;

  function automatic int instr_width(input int cond_w, input int op_w, input int reg_aw);
    return cond_w + op_w + 3 * reg_aw + 1;
  endfunction

  function automatic int cond_lsb(input int op_w, input int reg_aw);
    return op_w + 3 * reg_aw + 1;
  endfunction

  function automatic int op_lsb(input int reg_aw);
    return 3 * reg_aw + 1;
  endfunction

  function automatic int dest_lsb(input int reg_aw);
    return 2 * reg_aw + 1;
  endfunction

  function automatic int src1_lsb(input int reg_aw);
    return reg_aw + 1;
  endfunction

  // Decoded payload for the default field widths.
  typedef struct packed {
    logic [DEF_COND_W-1:0] cond;
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_REG_AW-1:0] dest;
    logic [DEF_REG_AW-1:0] src1;
    logic [DEF_REG_AW-1:0] src2;
    logic [DEF_REG_AW:0]   shift;
    logic                  is_shift;
    logic                  illegal;
    logic [DEF_TAG_W-1:0]  tag;
  } dec_payload_t;

endpackage

// File: rtl/instr_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so there is
// no combinational path from out_ready back to the producer.
module instr_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r, skid_valid_r, in_ready_r;
  logic [W-1:0] main_data_r, skid_data_r;
  logic         main_valid_s, skid_valid_s;
  logic [W-1:0] main_data_s, skid_data_s;
  logic         push_s, pop_s;

  assign push_s = in_valid && in_ready_r && !flush;
  assign pop_s  = main_valid_r && out_ready;

  // Next-state of main/skid; a pending skid word always refills main before new input.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_data_s  = {W{1'b0}};
      skid_valid_s = 1'b0;
      skid_data_s  = {W{1'b0}};
    end else if (pop_s || !main_valid_r) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
      end else if (push_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (push_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = in_data;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Storage registers and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= !skid_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: splits raw words into fields, classifies the opcode,
// tags each accepted word and hands the decoded payload to a skid buffer.
module instr_decode_stage
  import instr_dec_pkg::*;
#(
  parameter int                       COND_W          = DEF_COND_W,
  parameter int                       OP_W            = DEF_OP_W,
  parameter int                       REG_AW          = DEF_REG_AW,
  parameter int                       INSTR_W         = 16,
  parameter int                       TAG_W           = DEF_TAG_W,
  parameter logic [(1<<OP_W)-1:0]     SHIFT_OP_MASK   = DEF_SHIFT_OP_MASK,
  parameter logic [(1<<OP_W)-1:0]     ILLEGAL_OP_MASK = DEF_ILLEGAL_OP_MASK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COND_W-1:0]  out_cond,
  output logic [OP_W-1:0]    out_op,
  output logic [REG_AW-1:0]  out_dest,
  output logic [REG_AW-1:0]  out_src1,
  output logic [REG_AW-1:0]  out_src2,
  output logic [REG_AW:0]    out_shift,
  output logic               out_is_shift,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int SH_W      = REG_AW + 1;
  localparam int COND_LSB  = cond_lsb(OP_W, REG_AW);
  localparam int OP_LSB    = op_lsb(REG_AW);
  localparam int DEST_LSB  = dest_lsb(REG_AW);
  localparam int SRC1_LSB  = src1_lsb(REG_AW);

  if (INSTR_W != instr_width(COND_W, OP_W, REG_AW)) begin : g_width_check
    $error("INSTR_W must equal COND_W + OP_W + 3*REG_AW + 1");
  end

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [SH_W-1:0]   shift;
    logic              is_shift;
    logic              illegal;
    logic [TAG_W-1:0]  tag;
  } payload_t;

  payload_t         dec_s, out_s;
  logic [TAG_W-1:0] tag_cnt_r;
  logic             accept_s;

  assign accept_s = in_valid && in_ready && !flush;

  // Field split and opcode classification; src2 and shift share the low bits.
  always_comb begin
    dec_s.cond     = in_instr[COND_LSB +: COND_W];
    dec_s.op       = in_instr[OP_LSB +: OP_W];
    dec_s.dest     = in_instr[DEST_LSB +: REG_AW];
    dec_s.src1     = in_instr[SRC1_LSB +: REG_AW];
    dec_s.is_shift = SHIFT_OP_MASK[dec_s.op];
    dec_s.illegal  = ILLEGAL_OP_MASK[dec_s.op];
    dec_s.tag      = tag_cnt_r;
    if (dec_s.is_shift) begin
      dec_s.src2  = {REG_AW{1'b0}};
      dec_s.shift = in_instr[0 +: SH_W];
    end else begin
      dec_s.src2  = in_instr[1 +: REG_AW];
      dec_s.shift = {SH_W{1'b0}};
    end
  end

  // Sequence tag; survives flush, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_cnt_r <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      tag_cnt_r <= tag_cnt_r + TAG_W'(1);
    end else begin
      tag_cnt_r <= tag_cnt_r;
    end
  end

  instr_skid_buf #(
    .W($bits(payload_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_s)
  );

  assign out_cond     = out_s.cond;
  assign out_op       = out_s.op;
  assign out_dest     = out_s.dest;
  assign out_src1     = out_s.src1;
  assign out_src2     = out_s.src2;
  assign out_shift    = out_s.shift;
  assign out_is_shift = out_s.is_shift;
  assign out_illegal  = out_s.illegal;
  assign out_tag      = out_s.tag;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench: two decode stages (default masks, and shift/illegal masks set)
// share stimulus; expected payloads are queued on accept and compared on drain.
module tb_instr_decode_stage;
  import instr_dec_pkg::*;

  localparam logic [15:0] SMASK_B = 16'h0008;
  localparam logic [15:0] IMASK_B = 16'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = 16'h0000;

  logic       in_ready_a, out_valid_a, out_is_shift_a, out_illegal_a;
  logic [1:0] out_cond_a;
  logic [3:0] out_op_a, out_shift_a, out_tag_a;
  logic [2:0] out_dest_a, out_src1_a, out_src2_a;
  logic       in_ready_b, out_valid_b, out_is_shift_b, out_illegal_b;
  logic [1:0] out_cond_b;
  logic [3:0] out_op_b, out_shift_b, out_tag_b;
  logic [2:0] out_dest_b, out_src1_b, out_src2_b;

  dec_payload_t obs_a, obs_b;
  assign obs_a = {out_cond_a, out_op_a, out_dest_a, out_src1_a, out_src2_a,
                  out_shift_a, out_is_shift_a, out_illegal_a, out_tag_a};
  assign obs_b = {out_cond_b, out_op_b, out_dest_b, out_src1_b, out_src2_b,
                  out_shift_b, out_is_shift_b, out_illegal_b, out_tag_b};

  always #5 clk = ~clk;

  instr_decode_stage dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_cond(out_cond_a), .out_op(out_op_a), .out_dest(out_dest_a), .out_src1(out_src1_a),
    .out_src2(out_src2_a), .out_shift(out_shift_a), .out_is_shift(out_is_shift_a),
    .out_illegal(out_illegal_a), .out_tag(out_tag_a)
  );

  instr_decode_stage #(
    .SHIFT_OP_MASK(SMASK_B), .ILLEGAL_OP_MASK(IMASK_B)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_cond(out_cond_b), .out_op(out_op_b), .out_dest(out_dest_b), .out_src1(out_src1_b),
    .out_src2(out_src2_b), .out_shift(out_shift_b), .out_is_shift(out_is_shift_b),
    .out_illegal(out_illegal_b), .out_tag(out_tag_b)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  tag;
  } ent_t;

  ent_t       sb_q[$];
  logic [3:0] m_tag = 4'd0;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dec_payload_t expect_dec(input logic [15:0] w, input logic [3:0] tag,
                                              input logic [15:0] smask, input logic [15:0] imask);
    dec_payload_t d;
    d.cond     = w[15:14];
    d.op       = w[13:10];
    d.dest     = w[9:7];
    d.src1     = w[6:4];
    d.is_shift = smask[w[13:10]];
    d.illegal  = imask[w[13:10]];
    d.src2     = d.is_shift ? 3'd0 : w[3:1];
    d.shift    = d.is_shift ? w[3:0] : 4'd0;
    d.tag      = tag;
    return d;
  endfunction

  // Called on a falling edge: check state left by the last rising edge, then drive the next cycle.
  task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
    logic acc, drn;
    check_eq("a_out_valid", out_valid_a, sb_q.size() > 0);
    check_eq("b_out_valid", out_valid_b, sb_q.size() > 0);
    check_eq("a_in_ready", in_ready_a, sb_q.size() < 2);
    check_eq("b_in_ready", in_ready_b, sb_q.size() < 2);
    if (sb_q.size() > 0) begin
      check_eq("a_payload", obs_a, expect_dec(sb_q[0].instr, sb_q[0].tag, 16'h0000, 16'h0000));
      check_eq("b_payload", obs_b, expect_dec(sb_q[0].instr, sb_q[0].tag, SMASK_B, IMASK_B));
    end
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      sb_q.delete();
    end else begin
      acc = v && (sb_q.size() < 2);
      drn = (sb_q.size() > 0) && ordy;
      if (drn) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back('{instr: w, tag: m_tag});
        m_tag = m_tag + 4'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_instr  = 16'h0000;
    @(negedge clk);
    check_eq("rst_valid_a", out_valid_a, 1'b0);
    check_eq("rst_payload_a", obs_a, 32'h0);
    check_eq("rst_payload_b", obs_b, 32'h0);
    sb_q.delete();
    m_tag = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    @(negedge clk);
    do_reset();

    // Basic decode and shift-type decode of 0x4EAD.
    step(1'b1, 16'h4EAD, 1'b1, 1'b0);
    check_eq("basic_cond", out_cond_a, 2'd1);
    check_eq("basic_op", out_op_a, 4'd3);
    check_eq("basic_dest", out_dest_a, 3'd5);
    check_eq("basic_src1", out_src1_a, 3'd2);
    check_eq("basic_src2", out_src2_a, 3'd6);
    check_eq("basic_shift", out_shift_a, 4'd0);
    check_eq("basic_is_shift", out_is_shift_a, 1'b0);
    check_eq("basic_tag", out_tag_a, 4'd0);
    check_eq("shift_src2", out_src2_b, 3'd0);
    check_eq("shift_amount", out_shift_b, 4'd13);
    check_eq("shift_is_shift", out_is_shift_b, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: third word waits until the first drain frees skid.
    do_reset();
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b1, 1'b0);
    step(1'b1, 16'h3333, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("bp_third_tag", out_tag_a, 4'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush with both entries full and a word offered.
    do_reset();
    step(1'b1, 16'hA5A5, 1'b0, 1'b0);
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    step(1'b1, 16'hC3C3, 1'b0, 1'b1);
    step(1'b1, 16'h0F0F, 1'b1, 1'b0);
    check_eq("flush_tag_kept", out_tag_a, 4'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Tag wrap over 17 words; opcode i on word i so opcode 15 is seen.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom());
      w[13:10] = 4'(i);
      step(1'b1, w, 1'b1, 1'b0);
    end
    check_eq("wrap_tag15", out_tag_a, 4'd15);
    check_eq("illegal_b_op15", out_illegal_b, 1'b1);
    check_eq("illegal_a_op15", out_illegal_a, 1'b0);
    step(1'b1, 16'h4EAD, 1'b1, 1'b0);
    check_eq("wrap_tag0", out_tag_a, 4'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 80; i++) begin
      w = 16'($urandom());
      step(1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    step(1'b1, 16'h8888, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid_a", out_valid_a, 1'b0);
    check_eq("arst_valid_b", out_valid_b, 1'b0);
    check_eq("arst_payload_a", obs_a, 32'h0);
    check_eq("arst_payload_b", obs_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    m_tag = 4'd0;
    step(1'b1, 16'h9ABC, 1'b1, 1'b0);
    check_eq("post_rst_tag", out_tag_a, 4'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Parametrised, pipelined instruction decode stage. It takes raw instruction words from fetch over a valid/ready handshake and splits them into condition, opcode, register and shift fields. It also classifies the opcode (shift-type, illegal) and tags each instruction with a wrapping sequence number. Decoded results go to the register-read stage through a 2-entry skid buffer, so throughput is one instruction per cycle under back-pressure.

## Interface
Parameters:
- COND_W, 2, condition field width
- OP_W, 4, opcode field width
- REG_AW, 3, register address width
- INSTR_W, 16, instruction width; must equal COND_W+OP_W+3*REG_AW+1 (elaboration error otherwise)
- TAG_W, 4, sequence tag width
- SHIFT_OP_MASK, 16'h0000, bit k set means opcode k uses the shift field; width 2**OP_W
- ILLEGAL_OP_MASK, 16'h0000, bit k set means opcode k is illegal; width 2**OP_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept a word this cycle
- in_instr  in  INSTR_W  raw instruction
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  decoded instruction present
- out_ready  in  1  downstream accepts this cycle
- out_cond  out  COND_W  condition code
- out_op  out  OP_W  opcode
- out_dest  out  REG_AW  destination register
- out_src1  out  REG_AW  source register 1
- out_src2  out  REG_AW  source register 2; forced 0 for shift-type opcodes
- out_shift  out  REG_AW+1  shift amount; forced 0 for non-shift opcodes
- out_is_shift  out  1  SHIFT_OP_MASK[out_op]
- out_illegal  out  1  ILLEGAL_OP_MASK[out_op]
- out_tag  out  TAG_W  sequence tag

## Operation
- Field layout, MSB to LSB: cond, op, dest, src1, src2, spare bit 0.
- Shift field is the low REG_AW+1 bits (src2 plus bit 0).
- Decode is combinational on in_instr. The decoded payload, not the raw word, is stored.
- Accept: in_valid && in_ready && !flush.
- Each accepted word gets tag = tag_cnt; tag_cnt then increments modulo 2**TAG_W. The counter wraps from all-ones to 0.
- Storage is a main register (drives outputs) plus a skid register.
  - Accept while main is empty or being drained: the word goes to main.
  - Accept while main holds a word and out_ready=0: the word goes to skid.
  - Main drained (out_valid && out_ready) while skid holds a word: skid moves to main, and skid empties.
- in_ready = !skid_valid. It is driven from a register with no combinational path from out_ready.
- Flush has priority over everything. At the next edge, main and skid are cleared and the same-cycle input is dropped. tag_cnt is NOT reset.
- Illegal opcodes are passed through with out_illegal=1. They are never dropped.
- Reset (asynchronous, any time):
  - main and skid become invalid; tag_cnt=0.
  - All out_* data outputs = 0; out_valid=0.
  - in_ready=1 once reset deasserts.
  - An in-flight instruction is lost.

## Timing
- Latency: 1 cycle. An accept at edge N gives out_valid=1 after edge N.
- Throughput: 1 per cycle with out_ready held high.
- Stall: out_ready=0 with main full.
  - The next accept fills skid, and in_ready falls after that edge.
  - in_ready rises one cycle after the first drain.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new word replaces main, and out_valid stays 1.
- Simultaneous accept and drain with skid full: cannot occur, because in_ready=0.

## Structure
- Package instr_dec_pkg:
  - field offset/width functions of (COND_W, OP_W, REG_AW)
  - decoded-payload struct typedef
  - named opcode constants and default mask constants
- Sub-module instr_skid_buf: generic 2-entry valid/ready skid buffer parametrised by payload width. Instantiated once.
- The top contains the decode logic and the tag counter.

## Test plan
- Basic decode: after reset, send 0x4EAD with default masks and out_ready=1 -> the next cycle shows cond=1, op=3, dest=5, src1=2, src2=6, shift=0, is_shift=0, tag=0.
- Shift type: with SHIFT_OP_MASK bit 3 set, send 0x4EAD -> src2=0, shift=13, is_shift=1.
- Back-pressure: out_ready=0, send 3 words -> two are stored, in_ready=0 after the 2nd. Release out_ready -> words drain in order with tags 0,1, then the 3rd is accepted with tag 2.
- Flush: with both entries full, pulse flush while in_valid=1 -> out_valid=0 the next cycle and in_ready=1. The next accepted word carries tag 2, so the counter did not reset.
- Tag wrap: stream 17 words with TAG_W=4 -> tags 0..15, then 0. With ILLEGAL_OP_MASK bit 15 set, opcode 15 shows illegal=1.
- Reset mid-stall: assert reset asynchronously with both entries full -> out_valid=0 and all outputs 0 immediately; the first word after reset gets tag 0.
